// File: rtl/fetch_if.sv
// Fetch-side bundle: PC/instruction exchange with IF, redirect input, and the
// valid/ready delivery channel toward decode.
interface fetch_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic [INST_W-1:0] instruction;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [PC_W-1:0]   id_pc;
  logic [CNT_W-1:0]  buf_count;
  logic              misalign_err;

  modport master (
    output pc, id_valid, id_inst, id_pc, buf_count, misalign_err,
    input  pc_next, instruction, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  pc, id_valid, id_inst, id_pc, buf_count, misalign_err,
    output pc_next, instruction, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the combinational IF stage: captures {pc, inst}
// into a small prefetch FIFO, delivers to decode, and handles stall/redirect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | first cycle after reset release; pc held, nothing captured
// ST_RUN   | fetching; one capture per cycle while the buffer has room
// ST_STALL | buffer full and decode not accepting; pc held
module fetch_sequencer #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 2
) (
  input  logic      clk,
  input  logic      reset,
  fetch_if.master   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_misalign;
  logic [PC_W-1:0]   r_buf_pc   [DEPTH];
  logic [INST_W-1:0] r_buf_inst [DEPTH];

  logic              w_valid;
  logic              w_deq;
  logic              w_cap;
  logic [PC_W-1:0]   w_redirect_pc;

  assign w_valid = (r_count != '0);
  assign w_deq   = w_valid & bus.id_ready;
  // A full buffer still accepts a capture when the head leaves the same cycle.
  assign w_cap   = (r_state != ST_BOOT) & ~bus.redirect_valid
                 & ((r_count < FULL_CNT) | w_deq);
  assign w_redirect_pc = {bus.redirect_pc[PC_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_state  <= ST_RUN;
      r_pc     <= w_redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else begin
      if (w_cap) begin
        r_pc     <= bus.pc_next;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_cap) - CNT_W'(w_deq);
      if (r_state == ST_BOOT || w_cap) begin
        r_state <= ST_RUN;
      end else begin
        r_state <= ST_STALL;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_buf_pc[r_wr_ptr]   <= r_pc;
      r_buf_inst[r_wr_ptr] <= bus.instruction;
    end
  end

  assign bus.pc           = r_pc;
  assign bus.id_valid     = w_valid;
  assign bus.id_pc        = w_valid ? r_buf_pc[r_rd_ptr]   : '0;
  assign bus.id_inst      = w_valid ? r_buf_inst[r_rd_ptr] : '0;
  assign bus.buf_count    = r_count;
  assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer with a combinational IF model.
module tb_fetch_sequencer;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  fetch_if #(.PC_W(64), .INST_W(32), .DEPTH(2)) bus ();

  fetch_sequencer #(.PC_W(64), .RESET_PC(64'h0), .INST_W(32), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] p);
    return p[31:0] ^ 32'hA5C3_9E17;
  endfunction

  assign bus.pc_next     = bus.pc + 64'd4;
  assign bus.instruction = inst_of(bus.pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic [63:0] e_pc;
    logic        e_val;
    logic [63:0] e_idpc;
    logic [1:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic rv, input logic [63:0] rpc, input logic rdy,
                              input logic [63:0] e_pc, input logic e_val,
                              input logic [63:0] e_idpc, input logic [1:0] e_cnt,
                              input logic e_err);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_pc = e_pc; v.e_val = e_val;
    v.e_idpc = e_idpc; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic [63:0] e_pc, input logic e_val,
                         input logic [63:0] e_idpc, input logic [1:0] e_cnt, input logic e_err);
    logic [31:0] e_inst;
    e_inst = e_val ? inst_of(e_idpc) : 32'h0;
    chk({tag, "_pc"},       bus.pc,                   e_pc);
    chk({tag, "_valid"},    64'(bus.id_valid),        64'(e_val));
    chk({tag, "_id_pc"},    bus.id_pc,                e_idpc);
    chk({tag, "_id_inst"},  64'(bus.id_inst),         64'(e_inst));
    chk({tag, "_count"},    64'(bus.buf_count),       64'(e_cnt));
    chk({tag, "_misalign"}, 64'(bus.misalign_err),    64'(e_err));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    // rv, rpc, rdy | pc, id_valid, id_pc, count, misalign
    tbl[0]  = mk(0, 64'h0,   1, 64'h0,   0, 64'h0,   2'd0, 0); // BOOT
    tbl[1]  = mk(0, 64'h0,   1, 64'h4,   1, 64'h0,   2'd1, 0);
    tbl[2]  = mk(0, 64'h0,   1, 64'h8,   1, 64'h4,   2'd1, 0);
    tbl[3]  = mk(0, 64'h0,   1, 64'hC,   1, 64'h8,   2'd1, 0);
    tbl[4]  = mk(0, 64'h0,   0, 64'h10,  1, 64'h8,   2'd2, 0);
    tbl[5]  = mk(0, 64'h0,   0, 64'h10,  1, 64'h8,   2'd2, 0); // stall
    tbl[6]  = mk(0, 64'h0,   1, 64'h14,  1, 64'hC,   2'd2, 0); // full, deq+cap
    tbl[7]  = mk(1, 64'h100, 1, 64'h100, 0, 64'h0,   2'd0, 0); // redirect
    tbl[8]  = mk(0, 64'h0,   1, 64'h104, 1, 64'h100, 2'd1, 0);
    tbl[9]  = mk(1, 64'h203, 0, 64'h200, 0, 64'h0,   2'd0, 1); // misaligned
    tbl[10] = mk(0, 64'h0,   0, 64'h204, 1, 64'h200, 2'd1, 1);
    tbl[11] = mk(0, 64'h0,   0, 64'h208, 1, 64'h200, 2'd2, 1);
    tbl[12] = mk(0, 64'h0,   0, 64'h208, 1, 64'h200, 2'd2, 1);
    tbl[13] = mk(1, 64'h10,  0, 64'h10,  0, 64'h0,   2'd0, 1);
    tbl[14] = mk(1, 64'h44,  0, 64'h44,  0, 64'h0,   2'd0, 1); // back-to-back
    tbl[15] = mk(1, 64'h10,  0, 64'h10,  0, 64'h0,   2'd0, 1);
    tbl[16] = mk(0, 64'h0,   0, 64'h14,  1, 64'h10,  2'd1, 1);
    tbl[17] = mk(0, 64'h0,   0, 64'h18,  1, 64'h10,  2'd2, 1);
    tbl[18] = mk(0, 64'h0,   0, 64'h18,  1, 64'h10,  2'd2, 1);
    tbl[19] = mk(1, 64'h80,  1, 64'h80,  0, 64'h0,   2'd0, 1); // redirect+deq full
    tbl[20] = mk(0, 64'h0,   1, 64'h84,  1, 64'h80,  2'd1, 1);
    tbl[21] = mk(0, 64'h0,   1, 64'h88,  1, 64'h84,  2'd1, 1);

    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;
    bus.id_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_out("rst", 64'h0, 1'b0, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc    = tbl[i].rpc;
      bus.id_ready       = tbl[i].rdy;
      @(posedge clk);
      #1 chk_out($sformatf("v%0d", i), tbl[i].e_pc, tbl[i].e_val, tbl[i].e_idpc,
                 tbl[i].e_cnt, tbl[i].e_err);
      @(negedge clk);
    end

    // Fill to stall, then drop reset between edges.
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 chk_out("stall", 64'h8C, 1'b1, 64'h84, 2'd2, 1'b1);
    #2 reset = 1'b0;
    #1 chk_out("async_rst", 64'h0, 1'b0, 64'h0, 2'd0, 1'b0);

    // Redirect during BOOT, targeting the top of the address space to see pc wrap.
    @(negedge clk);
    reset = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk);
    #1 chk_out("boot_redir", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    @(posedge clk);
    #1 chk_out("wrap", 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
PC-side driver for the combinational IF stage: owns the program counter, presents it to IF as pc, and takes back IF's instruction and pc_next. Captures each fetched {pc, instruction} pair into a small skid/prefetch buffer and delivers it to decode over a valid/ready handshake. Handles decode back-pressure (stall) and branch/jump redirect (flush). Sits between the PC source logic and the IF/ID boundary.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
PC_W, 64, PC width.
INST_W, 32, instruction width.
DEPTH, 2, buffer entries; power of two, minimum 2.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = in reset).
pc  output  PC_W  current fetch address driven into IF.
pc_next  input  PC_W  IF's sequential next PC (pc+4), combinational from pc.
instruction  input  INST_W  IF's instruction at pc, combinational from pc.
redirect_valid  input  1  redirect request this cycle.
redirect_pc  input  PC_W  redirect target.
id_valid  output  1  buffer head valid toward decode.
id_ready  input  1  decode accepts head this cycle.
id_inst  output  INST_W  head instruction.
id_pc  output  PC_W  head instruction's PC.
buf_count  output  log2(DEPTH)+1  buffer occupancy.
misalign_err  output  1  sticky: a redirect_pc with bits[1:0] != 0 was taken.

Behaviour:
- Reset (reset=0, any time, async): pc=RESET_PC, buffer emptied, buf_count=0, id_valid=0, id_inst=0, id_pc=0, misalign_err=0, state=BOOT.
- States: BOOT, RUN, STALL.
- BOOT: exactly one cycle after reset release; no capture, pc held; -> RUN. Redirect in BOOT is honoured (pc<=redirect_pc) and state still -> RUN.
- Dequeue: deq = id_valid & id_ready; pops head at clock edge.
- Capture: cap = (state!=BOOT) & ~redirect_valid & (buf_count<DEPTH or deq). On cap: push {pc, instruction} at tail, pc<=pc_next.
- No cap in RUN/STALL (buffer full, no deq): pc held, state=STALL. STALL -> RUN on first cycle with deq or redirect.
- Full with deq in same cycle: capture proceeds, buf_count unchanged.
- Empty with cap: entry visible on id_valid the following cycle (1-cycle fetch-to-decode latency); no combinational bypass.
- Redirect (priority over everything except reset): next cycle pc={redirect_pc[PC_W-1:2],2'b00}, buffer flushed, buf_count=0, id_valid=0; no capture that cycle. A deq in the same cycle counts as delivered (decode consumed it); all other entries are discarded. If redirect_pc[1:0]!=0, misalign_err<=1 (cleared only by reset).
- Back-to-back redirects: each cycle's redirect wins; only the last target is fetched.
- id_inst/id_pc hold the head entry; they are 0 when the buffer is empty.
- pc wraps naturally modulo 2^PC_W. The block performs no arithmetic on pc; pc_next is taken verbatim from IF.
- buf_count is always in 0..DEPTH. Internal pointers wrap modulo DEPTH.

Test Plan:
- Reset/boot: hold reset=0 while clocking, then release with RESET_PC=0, id_ready=1, IF model inst=mem[pc>>2] -> pc=0 for 2 cycles, then 4, 8, 12. id_pc=0,4,8 from cycle 3, each with the matching id_inst. buf_count stays at or below 1.
- Back-pressure: id_ready=0 from the start -> two entries captured (pc 0,4), pc holds 8, buf_count=2, state STALL. Raise id_ready -> id_pc 0 is delivered while 8 is captured in the same cycle, and buf_count stays 2.
- Redirect: while streaming, pulse redirect_valid with redirect_pc=0x100 -> next cycle id_valid=0, buf_count=0, pc=0x100. Following cycle id_pc=0x100.
- Misaligned redirect: redirect_pc=0x203 -> pc=0x200, misalign_err=1, which stays 1 through later redirects until reset.
- Simultaneous redirect + deq with buffer full: head (pc 0x10) counts as consumed, entry 0x14 is discarded, and 0x14 is never presented again.
- Async reset mid-stall: drop reset between clock edges with buf_count=2 -> outputs go to reset values immediately, without waiting for a clock edge.
